pipe_rca: RTL and testbench
===========================

PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1: operands valid this cycle.
REQ-006 SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH: operand A.
REQ-008 SHALL have port b  input  WIDTH: operand B.
REQ-009 SHALL have port cin  input  1: carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1: 0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid  output  1: result valid.
REQ-012 SHALL have port out_ready  input  1: consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH: result bits.
REQ-014 SHALL have port cout  output  1: carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1: signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-016 SHALL implement STAGES register stages; stage k adds chunk k (bits k*CHUNK+CHUNK-1..k*CHUNK) with the carry registered from stage k-1.
REQ-017 SHALL carry not-yet-added upper operand chunks and already-computed lower sum chunks forward in skew registers alongside each stage's valid bit.
REQ-018 SHALL apply sub at acceptance: B inverted and chunk-0 carry-in forced to 1; operands latched with sub, so later changes to sub do not affect in-flight data.
REQ-019 SHALL have latency exactly STAGES cycles from accepted transfer (in_valid & in_ready) to out_valid when out_ready stays high.
REQ-020 SHALL sustain throughput of one result per cycle when out_ready is held high.
REQ-021 SHALL advance stage k when stage k is empty or stage k+1 advances; final stage advances when empty or out_ready=1 (bubbles collapse).
REQ-022 SHALL drive in_ready = stage 0 empty or stage 0 advancing; in_ready SHALL NOT depend on in_valid.
REQ-023 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL produce sum/cout/ovf equal to the full WIDTH-bit addition modulo 2^WIDTH, independent of CHUNK.
REQ-025 SHALL lose no transfer and duplicate none when in_valid and a stall occur in the same cycle, nor when a transfer is accepted in the same cycle a result leaves.
REQ-026 SHALL accept STAGES=1 (CHUNK=WIDTH) as a legal configuration with latency 1.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear all stage valid bits, drive out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 after reset.
REQ-028 SHALL discard all in-flight operations when reset asserts mid-operation; no result emerges after release.
REQ-029 SHALL accept a transfer on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place default WIDTH, default CHUNK and a STAGES-derivation function in shared package pipe_rca_pkg.
REQ-031 SHALL instantiate one combinational sub-module rca_chunk (CHUNK-bit ripple carry adder built from full adders, outputs sum, cout and MSB carry-in) per stage.
REQ-032 SHALL contain no combinational path from out_ready to sum/cout/ovf.

Verification
REQ-033 Reset then a=16'h00FF, b=16'h0001, cin=0, sub=0 -> after 4 cycles sum=16'h0100, cout=0, ovf=0.
REQ-034 a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> sum=16'h0000, cout=1, ovf=0; a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1.
REQ-035 a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cout=0; a=16'h8000, b=16'h0001, sub=1 -> sum=16'h7FFF, ovf=1.
REQ-036 10 back-to-back transfers (a=i, b=i, sub=0), out_ready=1 -> 10 consecutive results 2*i, in order, first at cycle 4.
REQ-037 Pipeline full, out_ready low 5 cycles -> in_ready=0 after 4 accepted, outputs held, no loss or duplication after release.
REQ-038 Reset asserted with 3 ops in flight -> out_valid=0 immediately; no stale result after release; random compare vs reference for WIDTH=32, CHUNK=8.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
// Provides the default operand width and chunk size, the stage-count
// derivation used by the top level, and the single-bit full-adder
// helper used to build each ripple-carry chunk.
package pipe_rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    // Number of pipeline stages for a given operand width and chunk size.
    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // One full adder: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipe_rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry adder built from a chain
// of full adders.
// Ports:
//   a, b   [CHUNK-1:0]  addend chunks
//   cin                 carry into bit 0
//   sum    [CHUNK-1:0]  chunk sum
//   cout                carry out of the chunk MSB
//   c_msb               carry into the chunk MSB (used for signed overflow)
module rca_chunk
    import pipe_rca_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] carry_s;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            {carry_s[i+1], sum[i]} = full_add(a[i], b[i], carry_s[i]);
        end
    end

    assign cout  = carry_s[CHUNK];
    assign c_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined ripple-carry adder/subtractor with valid/ready
// handshakes on both sides. Stage k adds operand chunk k using the carry
// registered by stage k-1; upper operand chunks not yet added and lower
// sum chunks already produced travel forward alongside each stage.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready independent of in_valid)
//   a, b [WIDTH-1:0]    operands
//   cin                 carry-in (ignored for subtraction)
//   sub                 1 = a - b, 0 = a + b + cin
//   out_valid/out_ready result handshake
//   sum [WIDTH-1:0]     result, cout carry out of MSB, ovf signed overflow
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] adv_s;
    logic [WIDTH-1:0]  b_eff_s;

    // Subtraction is folded in at acceptance so in-flight data never sees sub.
    assign b_eff_s  = sub ? ~b : b;
    assign in_ready = adv_s[0];

    // Backpressure chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv_s           = '0;
        adv_s[STAGES-1] = !valid_s[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv_s[k] = !valid_s[k] || adv_s[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW  = (k + 1) * CHUNK;   // sum bits produced so far
        localparam int OPW = WIDTH - SW;        // operand bits still to add

        logic             valid_r;
        logic             carry_r;
        logic [SW-1:0]    sum_r;
        logic [SW-1:0]    sum_nxt_s;
        logic [CHUNK-1:0] ca_s;
        logic [CHUNK-1:0] cb_s;
        logic [CHUNK-1:0] cs_s;
        logic             ci_s;
        logic             co_s;
        logic             cm_s;
        logic             v_in_s;

        if (k == 0) begin : g_src
            assign ca_s      = a[CHUNK-1:0];
            assign cb_s      = b_eff_s[CHUNK-1:0];
            assign ci_s      = sub ? 1'b1 : cin;
            assign v_in_s    = in_valid;
            assign sum_nxt_s = cs_s;
        end else begin : g_src
            assign ca_s      = g_stage[k-1].g_ops.a_r[CHUNK-1:0];
            assign cb_s      = g_stage[k-1].g_ops.b_r[CHUNK-1:0];
            assign ci_s      = g_stage[k-1].carry_r;
            assign v_in_s    = valid_s[k-1];
            assign sum_nxt_s = {cs_s, g_stage[k-1].sum_r};
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_rca (
            .a     (ca_s),
            .b     (cb_s),
            .cin   (ci_s),
            .sum   (cs_s),
            .cout  (co_s),
            .c_msb (cm_s)
        );

        assign valid_s[k] = valid_r;

        // Stage valid, accumulated sum and outgoing carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                sum_r   <= '0;
            end else if (adv_s[k]) begin
                valid_r <= v_in_s;
                if (v_in_s) begin
                    carry_r <= co_s;
                    sum_r   <= sum_nxt_s;
                end
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [OPW-1:0] a_r;
            logic [OPW-1:0] b_r;
            logic [OPW-1:0] a_hi_s;
            logic [OPW-1:0] b_hi_s;

            if (k == 0) begin : g_hi
                assign a_hi_s = a[WIDTH-1:CHUNK];
                assign b_hi_s = b_eff_s[WIDTH-1:CHUNK];
            end else begin : g_hi
                assign a_hi_s = g_stage[k-1].g_ops.a_r[OPW+CHUNK-1:CHUNK];
                assign b_hi_s = g_stage[k-1].g_ops.b_r[OPW+CHUNK-1:CHUNK];
            end

            // Skew register for the operand chunks later stages still need.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv_s[k] && v_in_s) begin
                    a_r <= a_hi_s;
                    b_r <= b_hi_s;
                end
            end
        end

        if (k == STAGES - 1) begin : g_out
            logic ovf_r;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (adv_s[k] && v_in_s) begin
                    ovf_r <= co_s ^ cm_s;
                end
            end

            assign out_valid = valid_r;
            assign sum       = sum_r;
            assign cout      = carry_r;
            assign ovf       = ovf_r;
        end else begin : g_out
            // Only the final chunk's MSB carry matters for overflow.
            logic unused_cm_s;
            assign unused_cm_s = cm_s;
        end
    end

endmodule

// File: tb/tb_pipe_rca.sv
// Self-checking bench for pipe_rca: three instances (16/4, 32/8, 16/16)
// checked every cycle against a behavioural arithmetic model.
module tb_pipe_rca;

    localparam int NI = 3;
    localparam int WD [NI] = '{16, 32, 16};
    localparam int ST [NI] = '{4, 4, 1};

    logic clk = 1'b0;
    logic rst_n;
    logic [NI-1:0] in_valid_v;
    logic [NI-1:0] in_ready_v;
    logic [NI-1:0] cin_v;
    logic [NI-1:0] sub_v;
    logic [NI-1:0] out_valid_v;
    logic [NI-1:0] out_ready_v;
    logic [NI-1:0] cout_v;
    logic [NI-1:0] ovf_v;
    logic [NI-1:0] lat_chk;
    logic [NI-1:0] stall_prev;
    logic [31:0]   a_v [NI];
    logic [31:0]   b_v [NI];
    logic [15:0]   sum0;
    logic [31:0]   sum1;
    logic [15:0]   sum2;

    logic [33:0] exp_val [NI][16];
    int          exp_cyc [NI][16];
    int          head [NI];
    int          tail [NI];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipe_rca #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

    pipe_rca #(.WIDTH(32), .CHUNK(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

    pipe_rca #(.WIDTH(16), .CHUNK(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2][15:0]), .b(b_v[2][15:0]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

    // Reference: plain w-bit arithmetic; returns {cout, ovf, sum[31:0]}.
    function automatic logic [33:0] ref_calc(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin,
                                             input logic sub);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned aa   = {32'd0, a} & mask;
        longint unsigned bb   = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        longint unsigned full = aa + bb + (sub ? 64'd1 : {63'd0, cin});
        logic [63:0]     fv   = full;
        logic [63:0]     av   = aa;
        logic [63:0]     bv   = bb;
        logic [31:0]     s    = fv[31:0] & mask[31:0];
        logic            co   = fv[w];
        logic            ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {co, ov, s};
    endfunction

    function automatic logic [33:0] res_of(input int i);
        case (i)
            0:       return {cout_v[0], ovf_v[0], 16'h0000, sum0};
            1:       return {cout_v[1], ovf_v[1], sum1};
            default: return {cout_v[2], ovf_v[2], 16'h0000, sum2};
        endcase
    endfunction

    task automatic chk(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: record accepted operations, compare every visible result.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [33:0] r;
            r = res_of(i);
            if (!rst_n) begin
                chk(out_valid_v[i] == 1'b0 && r == 34'd0 && in_ready_v[i] == 1'b1,
                    "reset_state", {out_valid_v[i], in_ready_v[i], r}, {2'b01, 34'd0});
                head[i]       = 0;
                tail[i]       = 0;
                stall_prev[i] = 1'b0;
            end else begin
                if (stall_prev[i])
                    chk(out_valid_v[i] == 1'b1, "hold_valid", out_valid_v[i], 1);
                if (out_valid_v[i]) begin
                    if (head[i] == tail[i]) begin
                        chk(1'b0, "unexpected_result", r, 0);
                    end else begin
                        chk(r == exp_val[i][head[i] % 16], "result", r,
                            exp_val[i][head[i] % 16]);
                        if (out_ready_v[i]) begin
                            if (lat_chk[i])
                                chk(cyc - exp_cyc[i][head[i] % 16] == ST[i], "latency",
                                    cyc - exp_cyc[i][head[i] % 16], ST[i]);
                            head[i]++;
                        end
                    end
                end
                stall_prev[i] = out_valid_v[i] && !out_ready_v[i];
                if (in_valid_v[i] && in_ready_v[i]) begin
                    exp_val[i][tail[i] % 16] = ref_calc(WD[i], a_v[i], b_v[i], cin_v[i], sub_v[i]);
                    exp_cyc[i][tail[i] % 16] = cyc;
                    tail[i]++;
                end
            end
        end
    end

    task automatic send(input int i, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb);
        int t = 0;
        in_valid_v[i] = 1'b1;
        a_v[i]        = av;
        b_v[i]        = bv;
        cin_v[i]      = ci;
        sub_v[i]      = sb;
        while (!in_ready_v[i] && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) chk(1'b0, "send_timeout", t, 50);
        @(posedge clk);
        #1;
        in_valid_v[i] = 1'b0;
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NI; i++) if (head[i] != tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain_all();
        int t = 0;
        in_valid_v  = '0;
        out_ready_v = '1;
        while (!all_empty() && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            chk(head[i] == tail[i] && out_valid_v[i] == 1'b0, "drain_empty",
                tail[i] - head[i], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit rdy;
        rst_n       = 1'b0;
        in_valid_v  = '0;
        out_ready_v = '1;
        cin_v       = '0;
        sub_v       = '0;
        lat_chk     = '0;
        for (int i = 0; i < NI; i++) begin
            a_v[i] = 32'd0;
            b_v[i] = 32'd0;
        end

        // Hand-computed anchors for the model itself.
        chk(ref_calc(16, 32'h00FF, 32'h0001, 1'b0, 1'b0) == {2'b00, 32'h0000_0100}, "model_add", ref_calc(16, 32'h00FF, 32'h0001, 1'b0, 1'b0), {2'b00, 32'h100});
        chk(ref_calc(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0) == {2'b10, 32'h0000_0000}, "model_wrap", ref_calc(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0), {2'b10, 32'h0});
        chk(ref_calc(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0) == {2'b01, 32'h0000_8000}, "model_ovf", ref_calc(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0), {2'b01, 32'h8000});
        chk(ref_calc(16, 32'h0005, 32'h0007, 1'b0, 1'b1) == {2'b00, 32'h0000_FFFE}, "model_sub", ref_calc(16, 32'h0005, 32'h0007, 1'b0, 1'b1), {2'b00, 32'hFFFE});
        chk(ref_calc(16, 32'h8000, 32'h0001, 1'b1, 1'b1) == {2'b11, 32'h0000_7FFF}, "model_sub_ovf", ref_calc(16, 32'h8000, 32'h0001, 1'b1, 1'b1), {2'b11, 32'h7FFF});
        chk(ref_calc(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0) == {2'b10, 32'h0}, "model_cin32", ref_calc(32, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0), {2'b10, 32'h0});

        // Release reset; the first edge after release must accept.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk(in_ready_v[0] == 1'b1, "ready_after_reset", in_ready_v[0], 1);
        lat_chk = '1;
        send(0, 32'h00FF, 32'h0001, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk(out_valid_v[0] == 1'b0, "latency_early", out_valid_v[0], 0);
        @(posedge clk);
        #1;
        chk(out_valid_v[0] == 1'b1 && sum0 == 16'h0100 && cout_v[0] == 1'b0 && ovf_v[0] == 1'b0,
            "first_result", {out_valid_v[0], cout_v[0], ovf_v[0], sum0}, {3'b100, 16'h0100});
        drain_all();

        // Directed corner values and back-to-back streaming.
        for (int i = 0; i < NI; i += 2) begin
            send(i, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
            send(i, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
            send(i, 32'h0005, 32'h0007, 1'b1, 1'b1);
            send(i, 32'h8000, 32'h0001, 1'b0, 1'b1);
            for (int n = 0; n < 10; n++) begin
                chk(in_ready_v[i] == 1'b1, "b2b_ready", in_ready_v[i], 1);
                send(i, n, n, 1'b0, 1'b0);
            end
            drain_all();
        end
        lat_chk = '0;

        // Output stall with continuous input: exactly STAGES accepted.
        for (int i = 0; i < NI; i += 2) begin
            out_ready_v[i] = 1'b0;
            acc = 0;
            for (int c = 0; c < 6; c++) begin
                in_valid_v[i] = 1'b1;
                a_v[i]   = $urandom;
                b_v[i]   = $urandom;
                cin_v[i] = 1'($urandom_range(0, 1));
                sub_v[i] = 1'($urandom_range(0, 1));
                rdy = in_ready_v[i];
                @(posedge clk);
                #1;
                if (rdy) acc++;
            end
            in_valid_v[i] = 1'b0;
            chk(acc == ST[i], "stall_accepts", acc, ST[i]);
            chk(in_ready_v[i] == 1'b0, "stall_ready", in_ready_v[i], 0);
            drain_all();
        end

        // Reset with operations in flight: nothing may emerge afterwards.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) send(i, $urandom, $urandom, 1'b0, 1'b0);
            #1;
            rst_n = 1'b0;
            #1;
            chk(out_valid_v[i] == 1'b0, "reset_async", out_valid_v[i], 0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            chk(out_valid_v[i] == 1'b0, "no_stale", out_valid_v[i], 0);
        end

        // Randomised traffic with random backpressure on all instances.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                in_valid_v[i]  = ($urandom_range(0, 9) < 7);
                out_ready_v[i] = ($urandom_range(0, 9) < 7);
                a_v[i]   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b_v[i]   = ($urandom_range(0, 7) == 0) ? 32'h8000_8000 : $urandom;
                cin_v[i] = 1'($urandom_range(0, 1));
                sub_v[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
